ahb_master_bridge: RTL

AHB_MASTER_BRIDGE -- requirements
Module: ahb_master_bridge

---
 rtl/ahb_pkg.sv | 50 +++++
 rtl/ahb_lane_steer.sv | 39 +++
 rtl/ahb_master_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, bridge FSM states and load/store funct3 helpers
// for the instruction/data master bridge.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'b000,
      HSIZE_HALF  = 3'b001,
      HSIZE_WORD  = 3'b010,
      HSIZE_DWORD = 3'b011
   } hsize_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_ERR2
   } bridge_state_e;

   localparam logic [3:0] HPROT_INSTR = 4'b0000;
   localparam logic [3:0] HPROT_DATA  = 4'b0001;

   // Stores reuse the LB/LH/LW encodings for SB/SH/SW.
   localparam logic [2:0] FN3_LB  = 3'b000;
   localparam logic [2:0] FN3_LH  = 3'b001;
   localparam logic [2:0] FN3_LW  = 3'b010;
   localparam logic [2:0] FN3_LBU = 3'b100;
   localparam logic [2:0] FN3_LHU = 3'b101;

   function automatic hsize_e fn3ToSize(input logic [2:0] fn3);
      case (fn3)
         FN3_LB, FN3_LBU: return HSIZE_BYTE;
         FN3_LH, FN3_LHU: return HSIZE_HALF;
         FN3_LW:          return HSIZE_WORD;
         default:         return HSIZE_WORD;
      endcase
   endfunction

   function automatic logic isMisaligned(input hsize_e size, input logic [1:0] addrLo);
      return ((size == HSIZE_HALF) && addrLo[0]) ||
             ((size == HSIZE_WORD) && (addrLo != 2'b00));
   endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Combinational byte-lane steering: replicates store data across lanes and
// extracts/extends load data from the addressed lane.
module ahb_lane_steer
   import ahb_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [2:0]                     i_size,
   input  logic                           i_unsigned,
   input  logic [$clog2(DATA_W/8)-1:0]    i_laneOff,
   input  logic [31:0]                    i_wdata,
   input  logic [DATA_W-1:0]              i_hrdata,
   output logic [DATA_W-1:0]              o_hwdata,
   output logic [31:0]                    o_rdata
);

   logic [DATA_W-1:0] w_shifted;

   assign w_shifted = i_hrdata >> {i_laneOff, 3'b000};

   always_comb begin
      o_hwdata = '0;
      case (i_size)
         HSIZE_BYTE: o_hwdata = {(DATA_W/8){i_wdata[7:0]}};
         HSIZE_HALF: o_hwdata = {(DATA_W/16){i_wdata[15:0]}};
         default:    o_hwdata = {(DATA_W/32){i_wdata}};
      endcase
   end

   always_comb begin
      o_rdata = '0;
      case (i_size)
         HSIZE_BYTE: o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
         HSIZE_HALF: o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         default:    o_rdata = w_shifted[31:0];
      endcase
   end

endmodule

// File: rtl/ahb_master_bridge.sv
// Bridges a core's instruction and data request ports onto a single AHB-Lite
// master, one transfer at a time, data port taking priority.
module ahb_master_bridge
   import ahb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 16
)(
   input  logic              hclk,
   input  logic              hreset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_fn3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [3:0]        hprot,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   localparam int OFF_W = $clog2(DATA_W/8);
   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   bridge_state_e     r_state, w_nextState;
   logic [ADDR_W-1:0] r_haddr;
   logic [2:0]        r_hsize;
   logic [3:0]        r_hprot;
   logic              r_we, r_ownerD, r_misalign, r_unsigned;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_waitCnt;
   logic              r_ifGnt, r_dGnt, r_ifRvalid, r_dRvalid, r_ifErr, r_dErr;
   logic [31:0]       r_ifRdata, r_dRdata;

   logic              w_grantD, w_grantI, w_done, w_fail, w_waitInc;
   hsize_e            w_dSize;
   logic              w_dMisalign;
   logic [DATA_W-1:0] w_hwdataRep;
   logic [31:0]       w_rdata;

   assign w_dSize     = fn3ToSize(d_fn3);
   assign w_dMisalign = isMisaligned(w_dSize, d_addr[1:0]);

   ahb_lane_steer #(.DATA_W(DATA_W)) u_steer (
      .i_size     (r_hsize),
      .i_unsigned (r_unsigned),
      .i_laneOff  (r_haddr[OFF_W-1:0]),
      .i_wdata    (r_wdata),
      .i_hrdata   (hrdata),
      .o_hwdata   (w_hwdataRep),
      .o_rdata    (w_rdata)
   );

   always_ff @(posedge hclk) begin
      if (hreset) r_state <= S_IDLE;
      else        r_state <= w_nextState;
   end

   // Grants are held off while a response is still visible so a port never
   // sees its rvalid and a new gnt together.
   always_comb begin
      w_nextState = r_state;
      w_grantD    = 1'b0;
      w_grantI    = 1'b0;
      w_done      = 1'b0;
      w_fail      = 1'b0;
      w_waitInc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!(r_ifRvalid || r_dRvalid)) begin
               if (d_req) begin
                  w_grantD    = 1'b1;
                  w_nextState = w_dMisalign ? S_DATA : S_ADDR;
               end else if (if_req) begin
                  w_grantI    = 1'b1;
                  w_nextState = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (hready) w_nextState = S_DATA;
         end
         S_DATA: begin
            if (r_misalign) begin
               w_nextState = S_ERR2;
            end else if (hresp) begin
               if (hready) begin
                  w_done      = 1'b1;
                  w_fail      = 1'b1;
                  w_nextState = S_IDLE;
               end else begin
                  w_nextState = S_ERR2;
               end
            end else if (hready) begin
               w_done      = 1'b1;
               w_nextState = S_IDLE;
            end else if (r_waitCnt == CNT_W'(WAIT_MAX - 1)) begin
               w_done      = 1'b1;
               w_fail      = 1'b1;
               w_nextState = S_IDLE;
            end else begin
               w_waitInc = 1'b1;
            end
         end
         S_ERR2: begin
            if (hready || r_misalign) begin
               w_done      = 1'b1;
               w_fail      = 1'b1;
               w_nextState = S_IDLE;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // A misaligned access never reaches the bus, so the address-phase
   // registers keep their previous values for it.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_haddr    <= '0;
         r_hsize    <= HSIZE_WORD;
         r_hprot    <= '0;
         r_we       <= 1'b0;
         r_ownerD   <= 1'b0;
         r_misalign <= 1'b0;
         r_unsigned <= 1'b0;
         r_wdata    <= '0;
         r_waitCnt  <= '0;
         r_ifGnt    <= 1'b0;
         r_dGnt     <= 1'b0;
         r_ifRvalid <= 1'b0;
         r_dRvalid  <= 1'b0;
         r_ifErr    <= 1'b0;
         r_dErr     <= 1'b0;
         r_ifRdata  <= '0;
         r_dRdata   <= '0;
      end else begin
         r_ifGnt    <= w_grantI;
         r_dGnt     <= w_grantD;
         r_ifRvalid <= w_done & ~r_ownerD;
         r_dRvalid  <= w_done & r_ownerD;
         r_ifErr    <= w_done & w_fail & ~r_ownerD;
         r_dErr     <= w_done & w_fail & r_ownerD;
         r_ifRdata  <= (w_done & ~w_fail & ~r_ownerD) ? w_rdata : '0;
         r_dRdata   <= (w_done & ~w_fail & r_ownerD & ~r_we) ? w_rdata : '0;
         r_waitCnt  <= w_waitInc ? r_waitCnt + CNT_W'(1) : '0;
         if (w_grantD) begin
            r_ownerD   <= 1'b1;
            r_we       <= d_we;
            r_wdata    <= d_wdata;
            r_unsigned <= d_fn3[2];
            r_misalign <= w_dMisalign;
            if (!w_dMisalign) begin
               r_haddr <= d_addr;
               r_hsize <= w_dSize;
               r_hprot <= HPROT_DATA;
            end
         end else if (w_grantI) begin
            r_ownerD   <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_unsigned <= 1'b1;
            r_misalign <= 1'b0;
            r_haddr    <= if_addr;
            r_hsize    <= HSIZE_WORD;
            r_hprot    <= HPROT_INSTR;
         end
      end
   end

   assign htrans    = (r_state == S_ADDR) ? NONSEQ : IDLE;
   assign hwrite    = (r_state == S_ADDR) & r_we;
   assign haddr     = r_haddr;
   assign hsize     = r_hsize;
   assign hprot     = r_hprot;
   assign hwdata    = ((r_state == S_DATA) && r_we && !r_misalign) ? w_hwdataRep : '0;
   assign if_gnt    = r_ifGnt;
   assign d_gnt     = r_dGnt;
   assign if_rvalid = r_ifRvalid;
   assign d_rvalid  = r_dRvalid;
   assign if_err    = r_ifErr;
   assign d_err     = r_dErr;
   assign if_rdata  = r_ifRdata;
   assign d_rdata   = r_dRdata;

endmodule
